// File: rtl/bmp_frame_arbiter_if.sv
// Bundle of the two slave beat ports, the shared downstream port and the
// frame status outputs of the BMP frame arbiter.
interface bmp_frame_arbiter_if #(
  parameter int DATA_BUS_SIZE = 32
);
  logic [1:0]               slv0_mode;
  logic                     slv0_data_valid;
  logic [DATA_BUS_SIZE-1:0] slv0_data;
  logic                     slv0_ready;
  logic [1:0]               slv1_mode;
  logic                     slv1_data_valid;
  logic [DATA_BUS_SIZE-1:0] slv1_data;
  logic                     slv1_ready;
  logic                     out_ready;
  logic [DATA_BUS_SIZE-1:0] out_data;
  logic                     out_valid;
  logic [1:0]               out_mode;
  logic                     out_hdr;
  logic                     out_sof;
  logic                     out_eof;
  logic [5:0]               out_last_bytes;
  logic [31:0]              file_size;
  logic [1:0]               grant;
  logic                     done;
  logic                     err_size;

  modport slave (
    input  slv0_mode, slv0_data_valid, slv0_data,
    input  slv1_mode, slv1_data_valid, slv1_data,
    input  out_ready,
    output slv0_ready, slv1_ready,
    output out_data, out_valid, out_mode, out_hdr, out_sof, out_eof, out_last_bytes,
    output file_size, grant, done, err_size
  );

  modport master (
    output slv0_mode, slv0_data_valid, slv0_data,
    output slv1_mode, slv1_data_valid, slv1_data,
    output out_ready,
    input  slv0_ready, slv1_ready,
    input  out_data, out_valid, out_mode, out_hdr, out_sof, out_eof, out_last_bytes,
    input  file_size, grant, done, err_size
  );
endinterface

// File: rtl/bmp_frame_arbiter.sv
// Frame-locked round-robin arbiter: grants one slave for a whole BMP file,
// parses file_size from the header and idles DEAD_TIME cycles between files.
module bmp_frame_arbiter #(
  parameter int DATA_BUS_SIZE = 32,
  parameter int HEADER_BYTES  = 56,
  parameter int DEAD_TIME     = 3
) (
  input logic               clk,
  input logic               rst,
  bmp_frame_arbiter_if.slave bus
);
  localparam int          BYTES      = DATA_BUS_SIZE / 8;
  localparam logic [32:0] BYTES_W    = 33'(BYTES);
  localparam logic [31:0] HDR_W      = 32'(HEADER_BYTES);
  localparam logic [31:0] DRAIN_LAST = 32'(DEAD_TIME - 1);
  localparam logic [1:0]  GRANT_NONE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DRAIN} state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_mode;
  logic        r_prio;
  logic [31:0] r_byte_cnt;
  logic [31:0] r_file_size;
  logic [31:0] r_eff_size;
  logic [31:0] r_drain_cnt;
  logic        r_err_size;
  logic        r_done;

  logic                     w_active;
  logic                     w_in_valid;
  logic [DATA_BUS_SIZE-1:0] w_in_data;
  logic                     w_beat;
  logic                     w_xfer;
  logic [32:0]              w_cnt_next;
  logic                     w_last_hdr;
  logic [31:0]              w_fs_next;
  logic [31:0]              w_eff_hdr;
  logic [31:0]              w_eff_cur;
  logic                     w_eof;
  logic                     w_elig0;
  logic                     w_elig1;
  logic                     w_winner;

  assign w_active = (r_state == S_HEADER) || (r_state == S_PAYLOAD);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_in_valid = 1'b0;
    w_in_data  = '0;
    case (r_grant)
      2'b00: begin
        w_in_valid = bus.slv0_data_valid;
        w_in_data  = bus.slv0_data;
      end
      2'b01: begin
        w_in_valid = bus.slv1_data_valid;
        w_in_data  = bus.slv1_data;
      end
      default: ;
    endcase
  end

  assign w_beat     = w_in_valid & w_active;
  assign w_xfer     = w_beat & bus.out_ready;
  assign w_cnt_next = {1'b0, r_byte_cnt} + BYTES_W;
  assign w_last_hdr = (r_state == S_HEADER) && (w_cnt_next == {1'b0, HDR_W});

  // Merge header bytes 2..5 of the current beat so the size is usable on the last header beat.
  always_comb begin
    w_fs_next = r_file_size;
    for (int i = 0; i < BYTES; i++) begin
      if ((r_byte_cnt + 32'(i)) inside {[32'd2:32'd5]})
        w_fs_next[{r_byte_cnt[1:0] + 2'(i) - 2'd2, 3'b000} +: 8] = w_in_data[8*i +: 8];
    end
  end

  assign w_eff_hdr = (w_fs_next < HDR_W) ? HDR_W : w_fs_next;
  assign w_eff_cur = (r_state == S_HEADER) ? w_eff_hdr : r_eff_size;

  always_comb begin
    w_eof = 1'b0;
    if (w_beat) begin
      if (r_state == S_HEADER) w_eof = w_last_hdr && (w_eff_hdr == HDR_W);
      else                     w_eof = (w_cnt_next >= {1'b0, r_eff_size});
    end
  end

  assign w_elig0  = bus.slv0_data_valid & (bus.slv0_mode[1] ^ bus.slv0_mode[0]);
  assign w_elig1  = bus.slv1_data_valid & (bus.slv1_mode[1] ^ bus.slv1_mode[0]);
  assign w_winner = (w_elig0 & w_elig1) ? r_prio : w_elig1;

  assign bus.slv0_ready     = (r_grant == 2'b00) & bus.out_ready & w_active;
  assign bus.slv1_ready     = (r_grant == 2'b01) & bus.out_ready & w_active;
  assign bus.out_data       = w_in_data;
  assign bus.out_valid      = w_beat;
  assign bus.out_mode       = r_mode;
  assign bus.out_hdr        = w_beat & (r_byte_cnt < HDR_W);
  assign bus.out_sof        = w_beat & (r_byte_cnt == 32'd0);
  assign bus.out_eof        = w_eof;
  assign bus.out_last_bytes = w_eof ? 6'(w_eff_cur - r_byte_cnt) : 6'd0;
  assign bus.file_size      = r_file_size;
  assign bus.grant          = r_grant;
  assign bus.done           = r_done;
  assign bus.err_size       = r_err_size;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= GRANT_NONE;
      r_mode      <= 2'b00;
      r_prio      <= 1'b0;
      r_byte_cnt  <= '0;
      r_file_size <= '0;
      r_eff_size  <= '0;
      r_drain_cnt <= '0;
      r_err_size  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_grant     <= {1'b0, w_winner};
            r_mode      <= w_winner ? bus.slv1_mode : bus.slv0_mode;
            r_byte_cnt  <= '0;
            r_file_size <= '0;
            r_err_size  <= 1'b0;
            r_state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_xfer) begin
            r_byte_cnt  <= w_cnt_next[31:0];
            r_file_size <= w_fs_next;
            if (w_last_hdr) begin
              r_eff_size <= w_eff_hdr;
              r_err_size <= (w_fs_next < HDR_W);
              if (w_eof) begin
                r_state     <= S_DRAIN;
                r_drain_cnt <= '0;
                r_done      <= (DEAD_TIME == 1);
              end else begin
                r_state <= S_PAYLOAD;
              end
            end
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_byte_cnt <= w_cnt_next[31:0];
            if (w_eof) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
              r_done      <= (DEAD_TIME == 1);
            end
          end
        end
        S_DRAIN: begin
          // done is pre-computed one cycle ahead so it is high exactly on the last drain cycle.
          if (r_drain_cnt == DRAIN_LAST) begin
            r_done  <= 1'b0;
            r_grant <= GRANT_NONE;
            r_prio  <= ~r_grant[0];
            r_state <= S_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 32'd1;
            r_done      <= ((r_drain_cnt + 32'd1) == DRAIN_LAST);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bmp_frame_arbiter.sv
// Directed bench for bmp_frame_arbiter: whole-file transfers, round-robin,
// invalid modes, undersized files, downstream stalls and mid-frame reset.
module tb_bmp_frame_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bmp_frame_arbiter_if #(.DATA_BUS_SIZE(32)) bus ();

  bmp_frame_arbiter #(
    .DATA_BUS_SIZE(32),
    .HEADER_BYTES (56),
    .DEAD_TIME    (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte k of a file is k^A5, except bytes 2..5 which carry the little-endian size.
  function automatic logic [31:0] beat_word(input int beat, input logic [31:0] size);
    logic [31:0] w;
    logic [7:0]  b;
    int          k;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      k = 4 * beat + i;
      if (k >= 2 && k <= 5) b = 8'(size >> (8 * (k - 2)));
      else                  b = 8'(k) ^ 8'hA5;
      w = {b, w[31:8]};
    end
    return w;
  endfunction

  task automatic drive(input int s, input logic [1:0] m, input logic v, input logic [31:0] d);
    if (s == 0) begin
      bus.slv0_mode = m; bus.slv0_data_valid = v; bus.slv0_data = d;
    end else begin
      bus.slv1_mode = m; bus.slv1_data_valid = v; bus.slv1_data = d;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " grant"},     bus.grant, 32'h2);
    check({name, " done"},      bus.done, 32'h0);
    check({name, " err_size"},  bus.err_size, 32'h0);
    check({name, " file_size"}, bus.file_size, 32'h0);
    check({name, " out_mode"},  bus.out_mode, 32'h0);
    check({name, " out_valid"}, bus.out_valid, 32'h0);
    check({name, " flags"},     {bus.out_hdr, bus.out_sof, bus.out_eof}, 32'h0);
    check({name, " last"},      bus.out_last_bytes, 32'h0);
    check({name, " readys"},    {bus.slv0_ready, bus.slv1_ready}, 32'h0);
    check({name, " out_data"},  bus.out_data, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 2'b00, 1'b0, 32'h0);
    drive(1, 2'b00, 1'b0, 32'h0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(input string name, input int sl, input logic [1:0] m,
                           input logic [31:0] size, input bit other_on,
                           input logic [1:0] other_m, input bit stall, input int rst_beat);
    int eff, nbeats, beat, gap, cyc;
    bit other_rdy, seen_eof, seen_done, aborted;
    eff = (size < 32'd56) ? 56 : int'(size);
    nbeats = (eff + 3) / 4;
    beat = 0; gap = 0; cyc = 0;
    other_rdy = 0; seen_eof = 0; seen_done = 0; aborted = 0;

    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(sl, m, 1'b1, beat_word(0, size));
    if (other_on) drive(1 - sl, other_m, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check({name, " arb-cycle ready"}, {bus.slv0_ready, bus.slv1_ready}, 32'h0);
    @(posedge clk); #1;
    check({name, " grant"}, bus.grant, 32'(sl));
    check({name, " out_mode"}, bus.out_mode, 32'(m));

    while (!seen_done && !aborted && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ((sl == 0) ? bus.slv1_ready : bus.slv0_ready) other_rdy = 1;
      if (bus.out_valid && bus.out_ready && !seen_eof) begin
        if (beat == rst_beat) begin
          rst = 1'b1;
          aborted = 1;
        end else begin
          check({name, " data"}, bus.out_data, beat_word(beat, size));
          check({name, " hdr"},  bus.out_hdr, 32'(beat < 14));
          check({name, " sof"},  bus.out_sof, 32'(beat == 0));
          check({name, " eof"},  bus.out_eof, 32'(beat == nbeats - 1));
          check({name, " last_bytes"}, bus.out_last_bytes,
                (beat == nbeats - 1) ? 32'(eff - 4 * (nbeats - 1)) : 32'h0);
          if (beat == nbeats - 1) seen_eof = 1;
          beat++;
        end
      end else if (seen_eof) begin
        gap++;
        check({name, " drain valid"}, bus.out_valid, 32'h0);
        check({name, " drain ready"}, {bus.slv0_ready, bus.slv1_ready}, 32'h0);
        if (bus.done) begin
          seen_done = 1;
          check({name, " done gap"},  32'(gap), 32'd3);
          check({name, " err_size"},  bus.err_size, 32'(size < 32'd56));
          check({name, " file_size"}, bus.file_size, size);
          check({name, " drain grant"}, bus.grant, 32'(sl));
        end
      end
      @(posedge clk); #1;
      if (!aborted) begin
        if (stall) bus.out_ready = ~bus.out_ready;
        if (seen_done) begin
          drive(0, 2'b00, 1'b0, 32'h0);
          drive(1, 2'b00, 1'b0, 32'h0);
        end else if (!seen_eof) begin
          drive(sl, m, 1'b1, beat_word(beat, size));
        end
      end
    end

    check({name, " other ready"}, 32'(other_rdy), 32'h0);
    if (aborted) begin
      check({name, " beats before reset"}, 32'(beat), 32'(rst_beat));
      @(negedge clk);
      check_idle_outputs({name, " in reset"});
      @(posedge clk); #1;
      drive(0, 2'b00, 1'b0, 32'h0);
      drive(1, 2'b00, 1'b0, 32'h0);
      bus.out_ready = 1'b1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check({name, " post-reset done"}, bus.done, 32'h0);
        check({name, " post-reset grant"}, bus.grant, 32'h2);
      end
    end else begin
      check({name, " done seen"}, 32'(seen_done), 32'h1);
      check({name, " beat count"}, 32'(beat), 32'(nbeats));
      @(negedge clk);
      check({name, " grant after done"}, bus.grant, 32'h2);
      check({name, " done pulse width"}, bus.done, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(0, 2'b00, 1'b0, 32'h0);
    drive(1, 2'b00, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame("f64",     0, 2'b01, 32'd64, 1'b0, 2'b00, 1'b0, -1);
    run_frame("f62",     0, 2'b01, 32'd62, 1'b0, 2'b00, 1'b0, -1);

    do_reset();
    run_frame("rr s0",   0, 2'b01, 32'd64, 1'b1, 2'b10, 1'b0, -1);
    run_frame("rr s1",   1, 2'b10, 32'd60, 1'b1, 2'b01, 1'b0, -1);
    run_frame("rr s0b",  0, 2'b01, 32'd68, 1'b1, 2'b10, 1'b0, -1);

    run_frame("mode11",  1, 2'b01, 32'd64, 1'b1, 2'b11, 1'b0, -1);
    run_frame("small",   0, 2'b01, 32'd20, 1'b0, 2'b00, 1'b0, -1);
    run_frame("stall",   0, 2'b10, 32'd64, 1'b0, 2'b00, 1'b1, -1);
    run_frame("stallrst",0, 2'b01, 32'd100, 1'b0, 2'b00, 1'b1, 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
